// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce -- per-key 2-flop synchronizer, tick-sampled debouncer and
// press/release/auto-repeat pulse generator. Define KEY_DEBOUNCE_REPEAT_EN to
// build the auto-repeat counters; otherwise key_repeat is tied to 0.
// Revision: 1.0
// ============================================================================
module key_debounce #(
  parameter int NUM_KEYS       = 5,
  parameter int SAMPLE_CYCLES  = 2000000,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_HIGH    = 1,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                sample_tick
);

  localparam int TICK_W = $clog2(SAMPLE_CYCLES);
  localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] sample;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                sample_tick_q, sample_tick_d;
  logic                tick_now;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    sample  = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;
  end

  // sample_tick is decoded from the next count so the registered pulse lines
  // up exactly with the cycle in which the count sits at its last value.
  always_comb begin
    tick_now      = (tick_cnt_q == TICK_LAST);
    tick_cnt_d    = tick_now ? '0 : tick_cnt_q + TICK_W'(1);
    sample_tick_d = (tick_cnt_d == TICK_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      tick_cnt_q    <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      tick_cnt_q    <= tick_cnt_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  assign sample_tick = sample_tick_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int DLY_W  = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam logic [DLY_W-1:0]  DLY_MAX   = DLY_W'(REPEAT_DELAY);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(REPEAT_DELAY - 1);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(REPEAT_RATE - 1);
`endif

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    logic [STAB_W-1:0] dis_cnt_q, dis_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;

    always_comb begin
      dis_cnt_d = dis_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick_now) begin
        if (sample[gi] != level_q) begin
          if (dis_cnt_q == STAB_LAST) begin
            dis_cnt_d = '0;
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
          end else begin
            dis_cnt_d = dis_cnt_q + STAB_W'(1);
          end
        end else begin
          dis_cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dis_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        dis_cnt_q <= dis_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[gi]   = level_q;
    assign key_press[gi]   = press_q;
    assign key_release[gi] = release_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic              repeat_q, repeat_d;

    // Delay counter saturates at REPEAT_DELAY; the rate counter then paces
    // the subsequent pulses. A releasing tick clears both and emits nothing.
    always_comb begin
      dly_cnt_d  = dly_cnt_q;
      rate_cnt_d = rate_cnt_q;
      repeat_d   = 1'b0;
      if (!level_q || release_d) begin
        dly_cnt_d  = '0;
        rate_cnt_d = '0;
      end else if (tick_now) begin
        if (dly_cnt_q != DLY_MAX) begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
          repeat_d  = (dly_cnt_q == DLY_LAST);
        end else if (rate_cnt_q == RATE_LAST) begin
          rate_cnt_d = '0;
          repeat_d   = 1'b1;
        end else begin
          rate_cnt_d = rate_cnt_q + RATE_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dly_cnt_q  <= '0;
        rate_cnt_q <= '0;
        repeat_q   <= 1'b0;
      end else begin
        dly_cnt_q  <= dly_cnt_d;
        rate_cnt_q <= rate_cnt_d;
        repeat_q   <= repeat_d;
      end
    end

    assign key_repeat[gi] = repeat_q;
`endif
  end

`ifndef KEY_DEBOUNCE_REPEAT_EN
  assign key_repeat = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// tb_key_debounce -- directed stimulus for key_debounce (active-high and
// active-low instances) checked against a tick-level model and literal values.
module tb_key_debounce;
  localparam int NK = 2;
  localparam int SC = 4;
  localparam int SS = 3;
  localparam int RD = 4;
  localparam int RR = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NK-1:0] key_in_p, key_in_n;
  logic [NK-1:0] level_p, press_p, rel_p, rep_p;
  logic [NK-1:0] level_n, press_n, rel_n, rep_n;
  logic          tick_p, tick_n;

  int n_tests = 0;
  int n_fail  = 0;
  int steps   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS(NK), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(SS),
    .ACTIVE_HIGH(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_p (
    .clk(clk), .rst(rst), .key_in(key_in_p),
    .key_level(level_p), .key_press(press_p), .key_release(rel_p),
    .key_repeat(rep_p), .sample_tick(tick_p)
  );

  key_debounce #(
    .NUM_KEYS(NK), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(SS),
    .ACTIVE_HIGH(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_n (
    .clk(clk), .rst(rst), .key_in(key_in_n),
    .key_level(level_n), .key_press(press_n), .key_release(rel_n),
    .key_repeat(rep_n), .sample_tick(tick_n)
  );

  // ---------------- behavioural model (index 0: active-high, 1: active-low)
  int            m_edges;
  logic [NK-1:0] m_h1 [2];
  logic [NK-1:0] m_h2 [2];
  logic [NK-1:0] m_now [2];
  bit            m_smp [2][NK][SS];
  logic [NK-1:0] m_level [2];
  logic [NK-1:0] m_press [2];
  logic [NK-1:0] m_rel [2];
  logic [NK-1:0] m_rep [2];
  int            m_held [2][NK];
  logic          m_tick;
  bit            m_s, m_all;

  // A key changes state once its last SS tick samples all disagree with it;
  // repeat fires RD ticks after the press and every RR ticks after that.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_edges = 0;
      m_tick  = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_h1[d] = '0; m_h2[d] = '0; m_level[d] = '0;
        m_press[d] = '0; m_rel[d] = '0; m_rep[d] = '0;
        for (int k = 0; k < NK; k++) begin
          m_held[d][k] = 0;
          for (int j = 0; j < SS; j++) m_smp[d][k][j] = 1'b0;
        end
      end
    end else begin
      m_now[0] = key_in_p;
      m_now[1] = key_in_n;
      m_edges++;
      m_tick = ((m_edges % SC) == SC - 1);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NK; k++) begin
          m_press[d][k] = 1'b0; m_rel[d][k] = 1'b0; m_rep[d][k] = 1'b0;
          if ((m_edges % SC) == 0) begin
            m_s = (d == 0) ? m_h2[d][k] : !m_h2[d][k];
            for (int j = SS - 1; j > 0; j--) m_smp[d][k][j] = m_smp[d][k][j-1];
            m_smp[d][k][0] = m_s;
            m_all = 1'b1;
            for (int j = 0; j < SS; j++)
              if (m_smp[d][k][j] == m_level[d][k]) m_all = 1'b0;
            if (m_all) begin
              if (m_level[d][k]) m_rel[d][k] = 1'b1;
              else begin
                m_press[d][k] = 1'b1;
                m_held[d][k]  = 0;
              end
              m_level[d][k] = !m_level[d][k];
            end else if (m_level[d][k]) begin
              m_held[d][k]++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              if (m_held[d][k] == RD || (m_held[d][k] > RD && ((m_held[d][k] - RD) % RR) == 0))
                m_rep[d][k] = 1'b1;
`endif
            end
          end
        end
        m_h2[d] = m_h1[d];
        m_h1[d] = m_now[d];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_tests++;
      if ({level_p, press_p, rel_p, rep_p, tick_p} !== {m_level[0], m_press[0], m_rel[0], m_rep[0], m_tick}) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL model_ah1 t=%0t got lvl=%b prs=%b rel=%b rep=%b tick=%b want lvl=%b prs=%b rel=%b rep=%b tick=%b",
                   $time, level_p, press_p, rel_p, rep_p, tick_p, m_level[0], m_press[0], m_rel[0], m_rep[0], m_tick);
      end
      n_tests++;
      if ({level_n, press_n, rel_n, rep_n, tick_n} !== {m_level[1], m_press[1], m_rel[1], m_rep[1], m_tick}) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL model_ah0 t=%0t got lvl=%b prs=%b rel=%b rep=%b tick=%b want lvl=%b prs=%b rel=%b rep=%b tick=%b",
                   $time, level_n, press_n, rel_n, rep_n, tick_n, m_level[1], m_press[1], m_rel[1], m_rep[1], m_tick);
      end
    end
  end

  // ---------------- directed stimulus and literal checks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    steps++;
  endtask

  function automatic logic [31:0] all_out();
    return {14'd0, level_p, press_p, rel_p, rep_p, tick_p, level_n, press_n, rel_n, rep_n, tick_n};
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clear", all_out(), 32'd0);
    repeat (3) step();
    check("rst_held_clear", all_out(), 32'd0);
    rst   = 1'b0;
    steps = 0;
  endtask

  // Steps until the given event appears (bounded); leaves steps at the hit.
  task automatic wait_press(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (press_p != '0) break;
    end
  endtask

  task automatic wait_release(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (rel_p != '0) break;
    end
  endtask

  int   rep_steps[$];
  int   exp_rep[$];
  int   first_rep;
  logic bad;

  initial begin
    rst = 1'b1;
    key_in_p = '0;
    key_in_n = '1;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_state", all_out(), 32'd0);
    rst   = 1'b0;
    steps = 0;

    // Steady press of key0 on both polarities
    key_in_p = 2'b01;
    key_in_n = 2'b10;
    wait_press(40);
    check("s1_press_edge", steps, 12);
    check("s1_press_val", press_p, 2'b01);
    check("s1_level", level_p, 2'b01);
    check("s1_level_low_active", level_n, 2'b01);
    check("s1_press_low_active", press_n, 2'b01);
    step();
    check("s1_press_one_clk", press_p, 2'b00);
    check("s1_level_holds", level_p, 2'b01);

    // Two-tick glitch on key0
    key_in_p = '0;
    key_in_n = '1;
    do_reset();
    key_in_p = 2'b01;
    bad = 1'b0;
    while (steps < 30) begin
      step();
      if (steps == 3) check("s2_tick_at_3", tick_p, 1'b1);
      if (steps == 4) check("s2_tick_off_4", tick_p, 1'b0);
      if (steps == 6) key_in_p = 2'b00;
      if ((level_p | press_p | rel_p) != '0) bad = 1'b1;
    end
    check("s2_glitch_ignored", bad, 1'b0);

    // Simultaneous press, later release of key1 only
    key_in_p = '0;
    do_reset();
    key_in_p = 2'b11;
    wait_press(40);
    check("s3_press_edge", steps, 12);
    check("s3_press_both", press_p, 2'b11);
    while (steps < 36) step();
    key_in_p = 2'b01;
    wait_release(60);
    check("s3_release_edge", steps, 48);
    check("s3_release_key1", rel_p, 2'b10);
    check("s3_level_key0", level_p, 2'b01);
    step();
    check("s3_release_one_clk", rel_p, 2'b00);

    // Release landing on what would be a repeat tick
    key_in_p = '0;
    do_reset();
    key_in_p = 2'b01;
    rep_steps.delete();
    while (steps < 60) begin
      step();
      if (steps == 40) key_in_p = 2'b00;
      if (steps == 52) check("s3b_release_edge", rel_p, 2'b01);
      if (rep_p[0]) rep_steps.push_back(steps);
    end
`ifdef KEY_DEBOUNCE_REPEAT_EN
    check("s3b_repeat_count", rep_steps.size(), 3);
`else
    check("s3b_repeat_count", rep_steps.size(), 0);
`endif

    // Long hold of key0: repeat schedule
    key_in_p = '0;
    do_reset();
    key_in_p = 2'b01;
    rep_steps.delete();
    exp_rep.delete();
`ifdef KEY_DEBOUNCE_REPEAT_EN
    exp_rep = '{28, 36, 44, 52, 60};
`endif
    while (steps < 62) begin
      step();
      if (rep_p != '0) rep_steps.push_back(steps);
    end
    check("s4_repeat_count", rep_steps.size(), exp_rep.size());
    for (int i = 0; i < exp_rep.size() && i < rep_steps.size(); i++)
      check("s4_repeat_edge", rep_steps[i], exp_rep[i]);

    // Reset while held and repeating, key stays held through release
    do_reset();
    wait_press(40);
    check("s5_press_after_reset", steps, 12);
    first_rep = -1;
    while (steps < 40) begin
      step();
      if (rep_p[0] && first_rep < 0) first_rep = steps;
    end
`ifdef KEY_DEBOUNCE_REPEAT_EN
    check("s5_first_repeat", first_rep, 28);
`else
    check("s5_first_repeat", first_rep, -1);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
